// File: rtl/debounce_bank.sv
// Bank of independent debouncers. Each channel has a synchroniser, a STABLE/CHECK
// filter, edge pulses, and an optional auto-repeat generator that drives press.
module debounce_bank #(
    parameter int NUM_CH          = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_RATE     = 10000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] pin,
    input  logic [NUM_CH-1:0] repeat_en,
    output logic [NUM_CH-1:0] state,
    output logic [NUM_CH-1:0] rise,
    output logic [NUM_CH-1:0] fall,
    output logic [NUM_CH-1:0] press
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = $clog2(RPT_MAX) + 1;

    localparam logic [DB_W-1:0]  DB_LOAD    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

    typedef enum logic {STABLE, CHECK} db_state_t;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync;
        logic                   s;
        db_state_t              cur, nxt;
        logic [DB_W-1:0]        cnt, cnt_nxt;
        logic                   st_q, rise_q, fall_q, press_q;
        logic                   st_nxt, rise_nxt, fall_nxt;
        logic [RPT_W-1:0]       rpt_cnt, rpt_cnt_nxt;
        logic                   rpt_started, rpt_started_nxt;
        logic                   rpt_active, rpt_hit, rpt_fire;

        assign s = sync[SYNC_STAGES-1];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync <= '0;
            end else begin
                sync <= {sync[SYNC_STAGES-2:0], pin[i]};
            end
        end

        always_comb begin
            nxt      = cur;
            cnt_nxt  = cnt;
            st_nxt   = st_q;
            rise_nxt = 1'b0;
            fall_nxt = 1'b0;
            case (cur)
                STABLE: begin
                    if (s != st_q) begin
                        cnt_nxt = DB_LOAD;
                        nxt     = CHECK;
                    end
                end
                CHECK: begin
                    if (s == st_q) begin
                        nxt = STABLE;
                    end else if (cnt == '0) begin
                        st_nxt   = s;
                        rise_nxt = s;
                        fall_nxt = ~s;
                        nxt      = STABLE;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                default: nxt = STABLE;
            endcase
        end

        // First repeat waits REPEAT_DELAY, later ones REPEAT_RATE; a fall this cycle vetoes it.
        always_comb begin
            rpt_active      = st_q & repeat_en[i];
            rpt_hit         = rpt_active & (rpt_started ? (rpt_cnt == RATE_LAST)
                                                        : (rpt_cnt == DELAY_LAST));
            rpt_fire        = rpt_hit & ~fall_nxt;
            rpt_cnt_nxt     = '0;
            rpt_started_nxt = 1'b0;
            if (rpt_active) begin
                rpt_cnt_nxt     = rpt_hit ? '0 : rpt_cnt + 1'b1;
                rpt_started_nxt = rpt_started | rpt_hit;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cur         <= STABLE;
                cnt         <= '0;
                st_q        <= 1'b0;
                rise_q      <= 1'b0;
                fall_q      <= 1'b0;
                press_q     <= 1'b0;
                rpt_cnt     <= '0;
                rpt_started <= 1'b0;
            end else begin
                cur         <= nxt;
                cnt         <= cnt_nxt;
                st_q        <= st_nxt;
                rise_q      <= rise_nxt;
                fall_q      <= fall_nxt;
                press_q     <= rise_nxt | rpt_fire;
                rpt_cnt     <= rpt_cnt_nxt;
                rpt_started <= rpt_started_nxt;
            end
        end

        assign state[i] = st_q;
        assign rise[i]  = rise_q;
        assign fall[i]  = fall_q;
        assign press[i] = press_q;
    end

endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank: directed scenarios plus random pin/enable/reset traffic,
// all outputs compared every cycle against a window-based behavioural model.
module tb_debounce_bank;

    localparam int NUM_CH = 4;
    localparam int SYNC   = 2;
    localparam int DB     = 4;
    localparam int RD     = 20;
    localparam int RR     = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NUM_CH-1:0] pin;
    logic [NUM_CH-1:0] repeat_en;
    logic [NUM_CH-1:0] state, rise, fall, press;

    int n_vec  = 0;
    int n_miss = 0;

    bit hist [NUM_CH][$];
    bit m_state [NUM_CH];
    int m_age [NUM_CH];
    logic [NUM_CH-1:0] exp_state, exp_rise, exp_fall, exp_press;

    debounce_bank #(
        .NUM_CH(NUM_CH), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pin(pin), .repeat_en(repeat_en),
        .state(state), .rise(rise), .fall(fall), .press(press)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // A level is accepted once the synchronised sample has disagreed with the
    // debounced level for DB+1 consecutive edges; repeats follow hold age.
    task automatic modelStep(input logic [NUM_CH-1:0] p, input logic [NUM_CH-1:0] en,
                             input logic rn);
        exp_state = '0; exp_rise = '0; exp_fall = '0; exp_press = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (!rn) begin
                hist[c].delete();
                m_state[c] = 1'b0;
                m_age[c]   = 0;
            end else begin
                bit prev, flip, sv, rep;
                int idx;
                prev = m_state[c];
                hist[c].push_back(p[c]);
                if (hist[c].size() > SYNC + DB + 4) void'(hist[c].pop_front());
                flip = 1'b1;
                for (int j = 0; j <= DB; j++) begin
                    idx = hist[c].size() - 1 - SYNC - j;
                    sv  = (idx >= 0) ? hist[c][idx] : 1'b0;
                    if (sv == prev) flip = 1'b0;
                end
                m_state[c] = flip ? ~prev : prev;
                if (prev && en[c]) m_age[c]++;
                else m_age[c] = 0;
                rep = prev && en[c] && !(flip && prev) && m_age[c] >= RD
                      && ((m_age[c] - RD) % RR) == 0;
                exp_state[c] = m_state[c];
                exp_rise[c]  = flip & ~prev;
                exp_fall[c]  = flip & prev;
                exp_press[c] = (flip & ~prev) | rep;
            end
        end
    endtask

    task automatic applyStimulus(input logic [NUM_CH-1:0] p, input logic [NUM_CH-1:0] en,
                                 input logic rn);
        @(negedge clk);
        pin       = p;
        repeat_en = en;
        rst_n     = rn;
        @(posedge clk);
        #1;
        modelStep(p, en, rn);
        checkOutput("state", 8'(state), 8'(exp_state));
        checkOutput("rise",  8'(rise),  8'(exp_rise));
        checkOutput("fall",  8'(fall),  8'(exp_fall));
        checkOutput("press", 8'(press), 8'(exp_press));
    endtask

    initial begin
        int np, nf, npost;
        bit fell;
        int hold [NUM_CH];
        logic [NUM_CH-1:0] rp, ren;

        rst_n = 1'b0; pin = '0; repeat_en = '0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0000, 4'b0000, 1'b0);
            checkOutput("reset_outs", 8'({state, rise, fall, press} != 0), 8'd0);
        end

        // Single rise on channel 0 exactly on the 7th edge.
        for (int i = 1; i <= 12; i++) begin
            applyStimulus(4'b0001, 4'b0000, 1'b1);
            if (i == 6) checkOutput("r029_state6", 8'(state), 8'h0);
            if (i == 7) checkOutput("r029_rise7", 8'(rise), 8'h1);
            if (i == 7) checkOutput("r029_press7", 8'(press), 8'h1);
        end
        for (int i = 0; i < 10; i++) applyStimulus(4'b0000, 4'b0000, 1'b1);

        // Short glitch on channel 1 is rejected.
        for (int i = 0; i < 3; i++) applyStimulus(4'b0010, 4'b0000, 1'b1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(4'b0000, 4'b0000, 1'b1);
            checkOutput("r030_quiet", 8'(state | rise | fall | press), 8'h0);
        end

        // Chatter on channel 2, then settle high: one rise 7 edges after last change.
        for (int i = 0; i < 20; i++) applyStimulus((i / 2) % 2 == 0 ? 4'b0100 : 4'b0000, 4'b0000, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(4'b0100, 4'b0000, 1'b1);
            if (i == 7) checkOutput("r031_rise", 8'(rise), 8'h4);
        end
        for (int i = 0; i < 10; i++) applyStimulus(4'b0000, 4'b0000, 1'b1);

        // Auto-repeat on channel 0: presses at rise offsets 0, 20, 28, 36.
        np = 0; nf = 0; npost = 0; fell = 1'b0;
        for (int i = 1; i <= 47; i++) begin
            applyStimulus(4'b0001, 4'b0001, 1'b1);
            if (press[0]) np++;
        end
        checkOutput("r032_presses", 8'(np), 8'd4);
        for (int i = 0; i < 15; i++) begin
            applyStimulus(4'b0000, 4'b0001, 1'b1);
            if (fall[0]) begin nf++; fell = 1'b1; end
            if (fell && press[0]) npost++;
        end
        checkOutput("r032_falls", 8'(nf), 8'd1);
        checkOutput("r032_post_press", 8'(npost), 8'd0);

        // Simultaneous rise on 0,1 and fall on 3.
        for (int i = 0; i < 12; i++) applyStimulus(4'b1000, 4'b0000, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(4'b0011, 4'b0000, 1'b1);
            if (i == 7) checkOutput("r033_rise", 8'(rise), 8'h3);
            if (i == 7) checkOutput("r033_fall", 8'(fall), 8'h8);
        end
        for (int i = 0; i < 12; i++) applyStimulus(4'b0000, 4'b0000, 1'b1);

        // Reset mid-CHECK with pin held high, then full latency after release.
        for (int i = 0; i < 4; i++) applyStimulus(4'b0001, 4'b0000, 1'b1);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(4'b0001, 4'b0000, 1'b0);
            checkOutput("r034_in_reset", 8'({state, rise, fall, press} != 0), 8'd0);
        end
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(4'b0001, 4'b0000, 1'b1);
            if (i == 6) checkOutput("r034_state6", 8'(state), 8'h0);
            if (i == 7) checkOutput("r034_rise7", 8'(rise), 8'h1);
        end

        // Random traffic with mixed glitches, long holds, enable changes and resets.
        rp = 4'b0001; ren = '0;
        for (int c = 0; c < NUM_CH; c++) hold[c] = $urandom_range(1, 30);
        for (int k = 0; k < 1500; k++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (hold[c] == 0) begin
                    rp[c]   = ~rp[c];
                    hold[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5))
                                                          : int'($urandom_range(6, 60));
                end else begin
                    hold[c]--;
                end
            end
            if ($urandom_range(0, 40) == 0) ren = 4'($urandom);
            applyStimulus(rp, ren, ($urandom_range(0, 500) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/debounce_bank.md
DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent input channels, minimum 1.
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser flop depth per channel, minimum 2.
REQ-003 Parameter DEBOUNCE_CYCLES, default 500000 (5 ms at 100 MHz): consecutive stable samples required to accept a level change, minimum 1.
REQ-004 Parameter REPEAT_DELAY, default 50000000: cycles from accepted press to first auto-repeat, minimum 1.
REQ-005 Parameter REPEAT_RATE, default 10000000: cycles between later auto-repeats, minimum 1.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 pin  input  NUM_CH  raw asynchronous inputs (buttons/switches).
REQ-009 repeat_en  input  NUM_CH  per-channel auto-repeat enable, synchronous to clk.
REQ-010 state  output  NUM_CH  debounced level per channel, registered.
REQ-011 rise  output  NUM_CH  one-cycle pulse when state goes 0->1.
REQ-012 fall  output  NUM_CH  one-cycle pulse when state goes 1->0.
REQ-013 press  output  NUM_CH  one-cycle pulse on every rise and every auto-repeat.

Function
REQ-014 Each channel SHALL pass pin[i] through a SYNC_STAGES-deep flop chain; its last stage is the synchronised sample s[i].
REQ-015 Each channel SHALL run its own two-state FSM, STABLE and CHECK, with a down-counter of width clog2(DEBOUNCE_CYCLES)+1.
REQ-016 In STABLE, s[i] != state[i] SHALL load the counter with DEBOUNCE_CYCLES-1 and move to CHECK; otherwise remain.
REQ-017 In CHECK, s[i] == state[i] SHALL return to STABLE with no output change (glitch rejected).
REQ-018 In CHECK, counter == 0 with s[i] != state[i] SHALL set state[i] <= s[i], pulse rise or fall in that same register update, and return to STABLE.
REQ-019 In CHECK, counter != 0 with s[i] != state[i] SHALL decrement the counter.
REQ-020 Latency: state, rise and fall SHALL change on exactly the (SYNC_STAGES+DEBOUNCE_CYCLES+1)th rising edge, counting from and including the first edge that samples the new pin level, provided the level is held.
REQ-021 Each accepted transition SHALL produce exactly one pulse; rise and fall SHALL never both be high for one channel.
REQ-022 Each channel SHALL have a repeat counter of width clog2(max(REPEAT_DELAY,REPEAT_RATE))+1, cleared whenever state[i]==0 or repeat_en[i]==0.
REQ-023 With state[i]==1 and repeat_en[i]==1, the first repeat pulse SHALL occur REPEAT_DELAY cycles after the rise pulse (or after repeat_en rises while held), then every REPEAT_RATE cycles.
REQ-024 press[i] SHALL equal rise[i] OR repeat pulse; a repeat coinciding with rise SHALL be impossible (counter is cleared at rise).
REQ-025 A fall SHALL stop auto-repeat in the same cycle; no press pulse on or after the fall cycle.
REQ-026 Channels SHALL be fully independent; simultaneous events on several channels SHALL produce simultaneous pulses.

Reset
REQ-027 rst_n low SHALL immediately clear synchronisers, state, rise, fall, press and all counters, and force every FSM to STABLE.
REQ-028 Reset mid-CHECK or mid-repeat SHALL abort it with no pulse; a pin held high across reset release SHALL produce rise after the full REQ-020 latency.

Verification (NUM_CH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8)
REQ-029 pin[0] 0->1 held -> state[0] and a single rise[0]/press[0] on the 7th edge; no other channel toggles.
REQ-030 pin[1] high for 3 cycles then low -> state[1] stays 0, no rise/fall/press.
REQ-031 pin[2] toggles every 2 cycles for 20 cycles then held high -> exactly one rise[2], 7 edges after the last transition.
REQ-032 repeat_en[0]=1, pin[0] held 40 cycles past rise -> press[0] at rise offsets 0, 20, 28, 36; release -> one fall[0], no further press.
REQ-033 pin[0],pin[1] rise and pin[3] falls (from stable 1) on the same edge -> rise[0], rise[1], fall[3] all pulse in the same cycle.
REQ-034 rst_n low 2 cycles during CHECK with pin still high -> all outputs 0 during reset, rise 7 edges after release.
